// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue constants: datapath width, default depth and the NOP encoding.
package fetch_queue_pkg;
  localparam int          FQ_WIDTH = 32;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] FQ_NOP   = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue. This is a circular buffer of {pc, instr} pairs,
// and every output comes from registered state only.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic [WIDTH-1:0]         instr_in,
  output logic                     fetch_ready,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [WIDTH-1:0]         id_pc,
  output logic [WIDTH-1:0]         id_pc_plus4,
  output logic [WIDTH-1:0]         id_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             push, pop;

  // Ready does not look at id_ready, so a full queue never passes an entry straight through.
  assign fetch_ready = (cnt_q != CW'(DEPTH));
  assign id_valid    = (cnt_q != '0);
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop         = id_valid && id_ready && !flush;
  assign count       = cnt_q;

  assign id_pc       = id_valid ? pc_mem[rd_ptr] : '0;
  assign id_instr    = id_valid ? instr_mem[rd_ptr] : WIDTH'(FQ_NOP);
  assign id_pc_plus4 = id_pc + WIDTH'(4);

  // Pointers wrap without help because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset. Only the pointers and the count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_in;
      instr_mem[wr_ptr] <= instr_in;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue. A queue model predicts the head entry, the count and ready.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, fetch_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0;
  logic        fetch_ready, id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
  logic [2:0]  count;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t sb[$];
  int checks = 0;
  int errors = 0;

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid),
    .pc_in(pc_in), .instr_in(instr_in), .fetch_ready(fetch_ready),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  // Compare every output against the model state.
  task automatic check_state(input string tag);
    chk({tag, ":count"}, 32'(count), 32'(sb.size()));
    chk({tag, ":ready"}, 32'(fetch_ready), 32'(sb.size() != DEPTH));
    chk({tag, ":valid"}, 32'(id_valid), 32'(sb.size() != 0));
    if (sb.size() == 0) begin
      chk({tag, ":pc0"}, id_pc, 32'h0);
      chk({tag, ":p40"}, id_pc_plus4, 32'h4);
      chk({tag, ":nop"}, id_instr, 32'h0);
    end else begin
      chk({tag, ":pc"}, id_pc, sb[0].pc);
      chk({tag, ":p4"}, id_pc_plus4, sb[0].pc + 32'd4);
      chk({tag, ":instr"}, id_instr, sb[0].instr);
    end
  endtask

  // Drive one cycle (the caller is at a negedge), update the model, then check at the next negedge.
  task automatic cyc(input string tag, input logic fv, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    logic do_push, do_pop;
    ent_t e;
    fetch_valid = fv; pc_in = pc; instr_in = mk_instr(pc); id_ready = rdy; flush = fl;
    do_push = fv && (sb.size() < DEPTH) && !fl;
    do_pop  = rdy && (sb.size() > 0) && !fl;
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin e.pc = pc; e.instr = mk_instr(pc); sb.push_back(e); end
    end
    @(negedge clk);
    fetch_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
    check_state(tag);
  endtask

  initial begin
    // Reset state
    #1 check_state("rst0");
    @(negedge clk); rst = 1'b1;
    check_state("rst1");

    // Fill to full, try a fifth push, then drain in order
    for (int i = 0; i < 5; i++) cyc("fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_rdy", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 5; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drained", 32'(id_valid), 32'd0);

    // Push and pop in the same cycle at count=2 with head 0x04
    for (int i = 0; i < 3; i++) cyc("pp_fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
    cyc("pp_pop", 1'b0, '0, 1'b1, 1'b0);
    chk("pp_head", id_pc, 32'h04);
    cyc("pp_both", 1'b1, 32'h0C, 1'b1, 1'b0);
    chk("pp_cnt", 32'(count), 32'd2);
    chk("pp_head2", id_pc, 32'h08);
    for (int i = 0; i < 3; i++) cyc("pp_drain", 1'b0, '0, 1'b1, 1'b0);

    // Ten interleaved pushes and pops, so the pointers wrap
    for (int i = 0; i < 10; i++) cyc("wrap", 1'b1, 32'(i * 4), 1'(i % 3 != 0), 1'b0);
    for (int i = 0; i < 6; i++) cyc("wrap_dr", 1'b0, '0, 1'b1, 1'b0);

    // Flush with count=3 while a push and a pop arrive in the same cycle
    for (int i = 0; i < 3; i++) cyc("fl_fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
    cyc("flush", 1'b1, 32'h40, 1'b1, 1'b1);
    chk("fl_cnt", 32'(count), 32'd0);
    cyc("fl_push", 1'b1, 32'h80, 1'b0, 1'b0);
    chk("fl_pc", id_pc, 32'h80);
    chk("fl_p4", id_pc_plus4, 32'h84);
    cyc("fl_dr", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in mid-cycle with count=3
    for (int i = 0; i < 3; i++) cyc("ar_fill", 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    sb.delete();
    chk("ar_cnt", 32'(count), 32'd0);
    chk("ar_vld", 32'(id_valid), 32'd0);
    chk("ar_nop", id_instr, 32'd0);
    chk("ar_rdy", 32'(fetch_ready), 32'd1);
    @(negedge clk); rst = 1'b1;
    cyc("ar_first", 1'b1, 32'h200, 1'b0, 1'b0);
    cyc("ar_dr", 1'b0, '0, 1'b1, 1'b0);

    // pc+4 wraps modulo 2^32
    cyc("wrap4", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("wrap4_p4", id_pc_plus4, 32'h0);
    cyc("wrap4_dr", 1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      cyc("rand", 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default `WIDTH (32), address/instruction data width.
REQ-002 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  branch/jump redirect; discards all queued entries.
REQ-006 fetch_valid  input  1  pc_in/instr_in hold a fetched instruction this cycle.
REQ-007 pc_in  input  WIDTH  PC of the fetched instruction (pc_out of the PC register).
REQ-008 instr_in  input  WIDTH  instruction word read from instruction memory at pc_in.
REQ-009 fetch_ready  output  1  queue can accept a push; PC register stall_pc = ~fetch_ready.
REQ-010 id_ready  input  1  decode stage consumes the head entry this cycle.
REQ-011 id_valid  output  1  head entry is valid.
REQ-012 id_pc  output  WIDTH  PC of the head entry.
REQ-013 id_pc_plus4  output  WIDTH  id_pc + 4, modulo 2^WIDTH.
REQ-014 id_instr  output  WIDTH  instruction of the head entry; NOP (all zeros) when empty.
REQ-015 count  output  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-016 Circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits; both pointers wrap from DEPTH-1 to 0.
REQ-017 Push occurs when fetch_valid && fetch_ready && !flush: {pc_in, instr_in} written at wr_ptr, wr_ptr increments.
REQ-018 Pop occurs when id_valid && id_ready && !flush: rd_ptr increments.
REQ-019 Push and pop in the same cycle: both occur, count unchanged.
REQ-020 fetch_ready = (count != DEPTH); depends only on registered state, not on id_ready (no pass-through when full).
REQ-021 id_valid = (count != 0); id_* outputs derived from the entry at rd_ptr, no combinational path from fetch_valid, pc_in, instr_in or id_ready.
REQ-022 Latency: instruction pushed at edge N visible on id_* in cycle after edge N when queue was empty (one-cycle fetch-to-decode latency).
REQ-023 When count == 0: id_instr = 0 (NOP), id_pc = 0, id_pc_plus4 = 4, id_valid = 0.
REQ-024 fetch_valid while full: no write, no state change; upstream holds the PC via stall_pc.
REQ-025 id_ready while empty: no pop, no state change.
REQ-026 flush: at the next edge count, wr_ptr, rd_ptr <= 0; simultaneous push and pop in that cycle are discarded; flush has priority over all other events.
REQ-027 Stored entries are not cleared by flush or pop; only pointers/count define validity.
REQ-028 count never exceeds DEPTH nor underflows below 0 under any input combination.

Reset
REQ-029 On rst low, asynchronously: count, wr_ptr, rd_ptr <= 0; outputs immediately id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4, fetch_ready=1.
REQ-030 Reset asserted mid-operation discards all entries; storage array need not be reset.
REQ-031 First push permitted on the first rising edge after rst deasserts.

Structure
REQ-032 WIDTH and the NOP encoding (32'h0000_0000) SHALL come from the shared defines file; FQ_DEPTH default defined there alongside.
REQ-033 Single flat module; no sub-module required; storage is a register array inside fetch_queue.

Verification
REQ-034 Reset: rst low mid-run with count=3 -> count=0, id_valid=0, id_instr=0, fetch_ready=1 without waiting for clk.
REQ-035 Fill/drain: id_ready=0, push PCs 0x00,0x04,0x08,0x0C -> count=4, fetch_ready=0; 5th push (0x10) ignored; then id_ready=1 -> id_pc 0x00,0x04,0x08,0x0C in order, then id_valid=0.
REQ-036 Simultaneous push/pop at count=2 (head 0x04) -> count stays 2, head becomes 0x08, new entry at tail.
REQ-037 Wrap-around: 10 pushes/pops interleaved through DEPTH=4 -> output PC sequence identical to input sequence 0x00..0x24.
REQ-038 Flush with count=3 plus push of 0x40 and pop same cycle -> next cycle count=0, id_valid=0; push of 0x80 next cycle -> id_pc=0x80, id_pc_plus4=0x84.
REQ-039 Wrap of pc+4: head PC 0xFFFF_FFFC -> id_pc_plus4=0x0000_0000.
